// File: rtl/perip_pump_ctrl_if.sv
// CPU-side peripheral bus: chip select, strobes, address and data.
interface perip_pump_ctrl_if;
    logic [31:0] d_in;
    logic [31:0] addr;
    logic [31:0] d_out;
    logic        cs;
    logic        rd;
    logic        wr;

    modport master (output d_in, addr, cs, rd, wr, input d_out);
    modport slave  (input d_in, addr, cs, rd, wr, output d_out);
endinterface

// File: rtl/perip_pump_ctrl.sv
// Irrigation pump controller: soft-start duty ramp, timed run, mandatory
// cool-down, low-level interlock, memory-mapped control and status.
//
// state | meaning
// IDLE  | pump off, waiting for start
// RAMP  | pump on, effective duty climbing by one every RAMP_MS ms
// RUN   | pump on, effective duty follows DUTY directly
// COOL  | pump off, holding off restarts for COOL_MS ms
module perip_pump_ctrl #(
    parameter int TICK_DIV = 25000,
    parameter int PWM_DIV  = 4,
    parameter int RAMP_MS  = 4,
    parameter int COOL_MS  = 2000
) (
    input  logic              clk,
    input  logic              rst,
    perip_pump_ctrl_if.slave  bus,
    input  logic              level_ok,
    output logic              pump_pwm,
    output logic              pump_on,
    output logic              irq_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int RW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
    localparam int CW = (COOL_MS > 0) ? $clog2(COOL_MS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_DIV - 1);
    localparam logic [RW-1:0] RAMP_LOAD = RW'(RAMP_MS - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOL_MS);

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_DUR    = 5'h04;
    localparam logic [4:0] A_DUTY   = 5'h08;
    localparam logic [4:0] A_STATUS = 5'h0C;
    localparam logic [4:0] A_REM    = 5'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        COOL = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   duration_q;
    logic [7:0]    duty_q;
    logic [23:0]   remaining_q, remaining_d;
    logic [7:0]    eff_duty_q, eff_duty_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [CW-1:0] cool_q, cool_d;
    logic [RW-1:0] ramp_q, ramp_d;
    logic [TW-1:0] tick_cnt;
    logic [PW-1:0] pwm_div_cnt;
    logic [7:0]    pwm_cnt;
    logic [31:0]   rdata;
    logic [7:0]    duty_now;
    logic          tick;

    logic [4:0] reg_addr;
    logic       wr_en, rd_en, ctrl_wr, start, stop, clr;
    logic       unused_bits;

    assign reg_addr    = bus.addr[4:0];
    assign wr_en       = bus.cs & bus.wr;
    assign rd_en       = bus.cs & bus.rd;
    assign ctrl_wr     = wr_en && (reg_addr == A_CTRL);
    assign start       = ctrl_wr & bus.d_in[0];
    assign stop        = ctrl_wr & bus.d_in[1];
    assign clr         = ctrl_wr & bus.d_in[2];
    assign unused_bits = ^{bus.addr[31:5], bus.d_in[31:24]};

    assign tick = (tick_cnt == TICK_LAST);

    // Free-running 1 ms prescaler; tick is high in the cycle it wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // PWM step prescaler and 8-bit PWM ramp counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_div_cnt <= '0;
            pwm_cnt     <= '0;
        end else if (pwm_div_cnt == PWM_LAST) begin
            pwm_div_cnt <= '0;
            pwm_cnt     <= pwm_cnt + 8'd1;
        end else begin
            pwm_div_cnt <= pwm_div_cnt + 1'b1;
        end
    end

    // Firmware-writable configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duration_q <= '0;
            duty_q     <= '0;
        end else if (wr_en) begin
            if (reg_addr == A_DUR)  duration_q <= bus.d_in[23:0];
            if (reg_addr == A_DUTY) duty_q     <= bus.d_in[7:0];
        end
    end

    // Read mux; status reflects the state before this edge's update.
    always_comb begin
        rdata = '0;
        case (reg_addr)
            A_DUR:    rdata = {8'd0, duration_q};
            A_DUTY:   rdata = {24'd0, duty_q};
            A_STATUS: rdata = {27'd0, level_ok, fault_q, done_q, state_q};
            A_REM:    rdata = {8'd0, remaining_q};
            default:  rdata = '0;
        endcase
    end

    // Read data is captured on cs&rd and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.d_out <= '0;
        end else if (rd_en) begin
            bus.d_out <= rdata;
        end
    end

    // Next-state and datapath; clear lands before any event can set flags.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        eff_duty_d  = eff_duty_q;
        done_d      = done_q;
        fault_d     = fault_q;
        cool_d      = cool_q;
        ramp_d      = ramp_q;

        if (clr) begin
            done_d  = 1'b0;
            fault_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!level_ok) begin
                        fault_d = 1'b1;
                    end else if (duration_q != 24'd0) begin
                        remaining_d = duration_q;
                        eff_duty_d  = 8'd0;
                        ramp_d      = RAMP_LOAD;
                        state_d     = RAMP;
                    end
                end
            end
            RAMP, RUN: begin
                if (!level_ok) begin
                    fault_d = 1'b1;
                    cool_d  = COOL_LOAD;
                    state_d = COOL;
                end else if (stop) begin
                    cool_d  = COOL_LOAD;
                    state_d = COOL;
                end else if (tick && (remaining_q <= 24'd1)) begin
                    remaining_d = 24'd0;
                    done_d      = 1'b1;
                    cool_d      = COOL_LOAD;
                    state_d     = COOL;
                end else begin
                    if (tick) remaining_d = remaining_q - 24'd1;
                    if (state_q == RUN) begin
                        eff_duty_d = duty_q;
                    end else if (eff_duty_q >= duty_q) begin
                        // Also covers DUTY lowered below the ramp mid-way.
                        eff_duty_d = duty_q;
                        state_d    = RUN;
                    end else if (tick) begin
                        if (ramp_q == '0) begin
                            eff_duty_d = eff_duty_q + 8'd1;
                            ramp_d     = RAMP_LOAD;
                        end else begin
                            ramp_d = ramp_q - 1'b1;
                        end
                    end
                end
            end
            COOL: begin
                if (tick) begin
                    if (cool_q <= CW'(1)) begin
                        cool_d  = '0;
                        state_d = IDLE;
                    end else begin
                        cool_d = cool_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and run datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            eff_duty_q  <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cool_q      <= '0;
            ramp_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            eff_duty_q  <= eff_duty_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cool_q      <= cool_d;
            ramp_q      <= ramp_d;
        end
    end

    // In RUN the live DUTY register drives the comparator so writes act at once.
    assign duty_now = (state_q == RUN) ? duty_q : eff_duty_q;
    assign pump_on  = (state_q == RAMP) || (state_q == RUN);
    assign pump_pwm = pump_on && (pwm_cnt < duty_now);
    assign irq_done = done_q;

endmodule

// File: tb/tb_perip_pump_ctrl.sv
// Bench for perip_pump_ctrl with a fast tick so whole runs fit in a few
// thousand cycles. Expected values come from tick-level rules of the block.
module tb_perip_pump_ctrl;

    localparam int TD = 10;
    localparam int PD = 2;
    localparam int RM = 1;
    localparam int CM = 3;

    localparam logic [4:0] A_CTRL = 5'h00;
    localparam logic [4:0] A_DUR  = 5'h04;
    localparam logic [4:0] A_DUTY = 5'h08;
    localparam logic [4:0] A_STAT = 5'h0C;
    localparam logic [4:0] A_REM  = 5'h10;
    localparam logic [4:0] A_BAD  = 5'h14;

    logic clk;
    logic rst;
    logic level_ok;
    logic pump_pwm;
    logic pump_on;
    logic irq_done;

    perip_pump_ctrl_if bus ();

    perip_pump_ctrl #(
        .TICK_DIV (TD),
        .PWM_DIV  (PD),
        .RAMP_MS  (RM),
        .COOL_MS  (CM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .level_ok (level_ok),
        .pump_pwm (pump_pwm),
        .pump_on  (pump_on),
        .irq_done (irq_done)
    );

    int total = 0;
    int bad   = 0;

    // Reference timebase: ms ticks land on every TD-th edge after reset release.
    int cyc;
    bit edge_tick;
    bit pend;
    int on_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) pend <= pump_on && ((cyc % TD) == TD - 1);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc       <= 0;
            edge_tick <= 1'b0;
            on_total  <= 0;
        end else begin
            edge_tick <= ((cyc % TD) == TD - 1);
            cyc       <= cyc + 1;
            if (pend) on_total <= on_total + 1;
        end
    end

    function automatic logic [31:0] stat(input int st, input bit dn, input bit ft, input bit lv);
        logic [1:0] s;
        s = st[1:0];
        return {27'd0, lv, ft, dn, s};
    endfunction

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.addr = 32'h0043_0000 | {27'd0, a};
        bus.d_in = v;
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        @(negedge clk);
        bus.cs   = 1'b0;
        bus.wr   = 1'b0;
    endtask

    task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.addr = 32'h0043_0000 | {27'd0, a};
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        @(negedge clk);
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        v        = bus.d_out;
    endtask

    task automatic wait_ticks(input int base, input int k, output bit to);
        to = 1'b1;
        for (int i = 0; i < (k + 2) * TD + 20; i++) begin
            if (on_total - base >= k) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_pump_off(input int limit, output bit to);
        to = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (!pump_on) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Polls STATUS every cycle; counts ms ticks spent in COOL until IDLE.
    task automatic wait_idle(output int cool_ticks, output bit to);
        cool_ticks = 0;
        to         = 1'b1;
        @(negedge clk);
        bus.addr = 32'h0043_0000 | {27'd0, A_STAT};
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.d_out[1:0] == 2'd3 && edge_tick) cool_ticks++;
            if (bus.d_out[1:0] == 2'd0) begin
                to = 1'b0;
                break;
            end
        end
        bus.cs = 1'b0;
        bus.rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst       = 1'b1;
        level_ok  = 1'b1;
        bus.cs    = 1'b0;
        bus.rd    = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = '0;
        bus.d_in  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.d_out !== 32'd0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.d_out); end
        total++; if ({pump_on, pump_pwm, irq_done} !== 3'b000) begin bad++; $display("FAIL reset_outs: got %b want 000", {pump_on, pump_pwm, irq_done}); end
        rd_reg(A_DUR, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_duration: got %h want 0", v); end
        rd_reg(A_DUTY, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_duty: got %h want 0", v); end
        rd_reg(A_REM, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_remaining: got %h want 0", v); end
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 0, 1)) begin bad++; $display("FAIL reset_status: got %h want %h", v, stat(0, 0, 0, 1)); end
    endtask

    task automatic test_run();
        logic [31:0] v;
        int d, n, base, ct;
        bit to;
        for (int it = 0; it < 2; it++) begin
            d = $urandom_range(2, 6);
            n = $urandom_range(d + 2, 25);
            wr_reg(A_DUTY, d);
            wr_reg(A_DUR, n);
            base = on_total;
            wr_reg(A_CTRL, 32'h1);
            rd_reg(A_STAT, v);
            total++; if (v !== stat(1, 0, 0, 1)) begin bad++; $display("FAIL run_ramp_state: got %h want %h", v, stat(1, 0, 0, 1)); end
            wait_ticks(base, d, to);
            total++; if (to) begin bad++; $display("FAIL run_ramp_ticks: got timeout want %0d ticks", d); end
            rd_reg(A_STAT, v);
            total++; if (v !== stat(2, 0, 0, 1)) begin bad++; $display("FAIL run_run_state: got %h want %h (duty %0d)", v, stat(2, 0, 0, 1), d); end
            wait_pump_off((n + 2) * TD, to);
            total++; if (to) begin bad++; $display("FAIL run_end_timeout: got pump_on stuck want off after %0d ticks", n); end
            total++; if (on_total - base !== n) begin bad++; $display("FAIL run_on_ticks: got %0d want %0d", on_total - base, n); end
            total++; if (irq_done !== 1'b1) begin bad++; $display("FAIL run_irq_done: got %b want 1", irq_done); end
            rd_reg(A_STAT, v);
            total++; if (v !== stat(3, 1, 0, 1)) begin bad++; $display("FAIL run_done_status: got %h want %h", v, stat(3, 1, 0, 1)); end
            rd_reg(A_REM, v);
            total++; if (v !== 32'd0) begin bad++; $display("FAIL run_remaining: got %0d want 0", v); end
            wait_idle(ct, to);
            total++; if (to || ct != CM) begin bad++; $display("FAIL run_cool_ticks: got %0d (timeout %b) want %0d", ct, to, CM); end
            wr_reg(A_CTRL, 32'h4);
            total++; if (irq_done !== 1'b0) begin bad++; $display("FAIL run_clear_irq: got %b want 0", irq_done); end
            rd_reg(A_STAT, v);
            total++; if (v !== stat(0, 0, 0, 1)) begin bad++; $display("FAIL run_clear_status: got %h want %h", v, stat(0, 0, 0, 1)); end
        end
    endtask

    task automatic test_pwm();
        logic [31:0] v;
        int d, base, hi, ct;
        bit to;
        for (int k = 0; k < 3; k++) begin
            d = (k == 0) ? 128 : (k == 1) ? int'($urandom_range(1, 200)) : 0;
            wr_reg(A_DUTY, d);
            wr_reg(A_DUR, d + 120);
            base = on_total;
            wr_reg(A_CTRL, 32'h1);
            if (d == 0) begin
                rd_reg(A_STAT, v);
                total++; if (v !== stat(2, 0, 0, 1)) begin bad++; $display("FAIL pwm_zero_run: got %h want %h", v, stat(2, 0, 0, 1)); end
            end
            wait_ticks(base, d + 1, to);
            total++; if (to) begin bad++; $display("FAIL pwm_ramp_timeout: got timeout want %0d ticks", d + 1); end
            hi = 0;
            for (int i = 0; i < 256 * PD; i++) begin
                @(negedge clk);
                if (pump_pwm) hi++;
            end
            total++; if (hi != d * PD) begin bad++; $display("FAIL pwm_high_count: got %0d want %0d (duty %0d)", hi, d * PD, d); end
            wr_reg(A_DUTY, 32'h0);
            hi = 0;
            for (int i = 0; i < 256 * PD; i++) begin
                if (pump_pwm) hi++;
                @(negedge clk);
            end
            total++; if (hi != 0) begin bad++; $display("FAIL pwm_live_zero: got %0d want 0", hi); end
            wr_reg(A_CTRL, 32'h2);
            wait_idle(ct, to);
            total++; if (to) begin bad++; $display("FAIL pwm_idle_timeout: got timeout want IDLE"); end
        end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        int d, base, ct;
        bit to;
        d = $urandom_range(1, 4);
        wr_reg(A_DUTY, d);
        wr_reg(A_DUR, 40);
        base = on_total;
        wr_reg(A_CTRL, 32'h1);
        wait_ticks(base, d + 1, to);
        total++; if (to) begin bad++; $display("FAIL abort_ramp_timeout: got timeout want %0d ticks", d + 1); end
        level_ok = 1'b0;
        @(negedge clk);
        total++; if (pump_on !== 1'b0) begin bad++; $display("FAIL abort_pump_on: got %b want 0", pump_on); end
        rd_reg(A_STAT, v);
        total++; if (v !== stat(3, 0, 1, 0)) begin bad++; $display("FAIL abort_status: got %h want %h", v, stat(3, 0, 1, 0)); end
        rd_reg(A_REM, v);
        total++; if (v !== 32'(40 - (d + 1))) begin bad++; $display("FAIL abort_remaining: got %0d want %0d", v, 40 - (d + 1)); end
        wait_idle(ct, to);
        total++; if (to) begin bad++; $display("FAIL abort_idle_timeout: got timeout want IDLE"); end
        wr_reg(A_CTRL, 32'h5);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 1, 0)) begin bad++; $display("FAIL abort_low_start: got %h want %h", v, stat(0, 0, 1, 0)); end
        level_ok = 1'b1;
        wr_reg(A_CTRL, 32'h4);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 0, 1)) begin bad++; $display("FAIL abort_cleared: got %h want %h", v, stat(0, 0, 0, 1)); end
    endtask

    task automatic test_stop();
        logic [31:0] v;
        int n, base, ct;
        bit to;
        n = $urandom_range(12, 20);
        wr_reg(A_DUTY, $urandom_range(1, 3));
        wr_reg(A_DUR, n);
        base = on_total;
        wr_reg(A_CTRL, 32'h1);
        wait_ticks(base, n - 7, to);
        total++; if (to) begin bad++; $display("FAIL stop_wait_timeout: got timeout want %0d ticks", n - 7); end
        wr_reg(A_CTRL, 32'h2);
        rd_reg(A_REM, v);
        total++; if (v !== 32'd7) begin bad++; $display("FAIL stop_remaining: got %0d want 7", v); end
        rd_reg(A_STAT, v);
        total++; if (v !== stat(3, 0, 0, 1)) begin bad++; $display("FAIL stop_status: got %h want %h", v, stat(3, 0, 0, 1)); end
        wr_reg(A_CTRL, 32'h1);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(3, 0, 0, 1)) begin bad++; $display("FAIL stop_cool_start: got %h want %h", v, stat(3, 0, 0, 1)); end
        wait_idle(ct, to);
        total++; if (to) begin bad++; $display("FAIL stop_idle_timeout: got timeout want IDLE"); end
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 0, 1)) begin bad++; $display("FAIL stop_not_queued: got %h want %h", v, stat(0, 0, 0, 1)); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] v;
        int base, ct;
        bit to;
        wr_reg(A_DUR, 32'h0);
        wr_reg(A_CTRL, 32'h1);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 0, 1) || pump_on !== 1'b0) begin bad++; $display("FAIL sim_zero_duration: got %h on=%b want %h on=0", v, pump_on, stat(0, 0, 0, 1)); end
        level_ok = 1'b0;
        wr_reg(A_CTRL, 32'h1);
        level_ok = 1'b1;
        wr_reg(A_DUR, 30);
        wr_reg(A_DUTY, 3);
        base = on_total;
        wr_reg(A_CTRL, 32'h3);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(1, 0, 1, 1)) begin bad++; $display("FAIL sim_stop_start_idle: got %h want %h", v, stat(1, 0, 1, 1)); end
        wait_ticks(base, 4, to);
        rd_reg(A_STAT, v);
        total++; if (to || v !== stat(2, 0, 1, 1)) begin bad++; $display("FAIL sim_run_fault: got %h (timeout %b) want %h", v, to, stat(2, 0, 1, 1)); end
        wr_reg(A_CTRL, 32'h7);
        rd_reg(A_STAT, v);
        total++; if (v !== stat(3, 0, 0, 1)) begin bad++; $display("FAIL sim_clear_start_stop: got %h want %h", v, stat(3, 0, 0, 1)); end
        wait_idle(ct, to);
        total++; if (to) begin bad++; $display("FAIL sim_idle_timeout: got timeout want IDLE"); end
    endtask

    task automatic test_bus_reset();
        logic [31:0] v, dur;
        int base;
        bit to;
        dur = {8'd0, 24'($urandom_range(1, 24'hFFFFFF))};
        wr_reg(A_DUR, dur);
        wr_reg(A_BAD, $urandom);
        rd_reg(A_BAD, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL bus_unmapped: got %h want 0", v); end
        @(negedge clk);
        bus.addr = 32'h0043_0000 | {27'd0, A_DUR};
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        total++; if (bus.d_out !== 32'd0) begin bad++; $display("FAIL bus_latency_before: got %h want 0", bus.d_out); end
        @(negedge clk);
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        total++; if (bus.d_out !== dur) begin bad++; $display("FAIL bus_latency_after: got %h want %h", bus.d_out, dur); end
        @(negedge clk);
        total++; if (bus.d_out !== dur) begin bad++; $display("FAIL bus_hold: got %h want %h", bus.d_out, dur); end
        wr_reg(A_DUTY, 2);
        wr_reg(A_DUR, 50);
        base = on_total;
        wr_reg(A_CTRL, 32'h1);
        wait_ticks(base, 3, to);
        rd_reg(A_DUTY, v);
        total++; if (to || pump_on !== 1'b1 || v !== 32'd2) begin bad++; $display("FAIL bus_prerst_run: got on=%b duty=%h want on=1 duty=2", pump_on, v); end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if ({pump_on, pump_pwm, irq_done} !== 3'b000 || bus.d_out !== 32'd0) begin bad++; $display("FAIL bus_async_rst: got outs=%b dout=%h want 000 and 0", {pump_on, pump_pwm, irq_done}, bus.d_out); end
        @(negedge clk);
        rst = 1'b0;
        rd_reg(A_DUR, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL bus_rst_duration: got %h want 0", v); end
        rd_reg(A_DUTY, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL bus_rst_duty: got %h want 0", v); end
        rd_reg(A_REM, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL bus_rst_remaining: got %h want 0", v); end
        rd_reg(A_STAT, v);
        total++; if (v !== stat(0, 0, 0, 1)) begin bad++; $display("FAIL bus_rst_status: got %h want %h", v, stat(0, 0, 0, 1)); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pwm();
        test_abort();
        test_stop();
        test_simultaneous();
        test_bus_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
